// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared microsequencer types, stack ops and next-address mux selects
package ctrl_pkg;
  localparam int AW_DEF = 32;
  typedef logic [AW_DEF-1:0] uaddr_t;
  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;
  localparam logic [1:0] SEL_PC     = 2'b00;
  localparam logic [1:0] SEL_SUB    = 2'b01;
  localparam logic [1:0] SEL_SECOND = 2'b10;
  localparam logic [1:0] SEL_BRN    = 2'b11;
endpackage

// File: rtl/microseq_return_stack.sv
// microseq_return_stack: LIFO return-address stack; RSTACK_ERR_STICKY_EN makes overflow/underflow sticky with err_clr
module microseq_return_stack
  import ctrl_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
`ifdef RSTACK_ERR_STICKY_EN
  input  logic          err_clr,
`endif
  output logic [AW-1:0] top_addr,
  output logic [AW-1:0] second_addr,
  output logic [CW-1:0] depth,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);
  logic [DEPTH-1:0][AW-1:0] entry_q, entry_d;
  logic [CW-1:0] depth_q, depth_d;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic do_push, do_pop, do_repl, ovf_ev, unf_ev;
  stack_op_e op;
  assign empty       = depth_q == '0;
  assign full        = depth_q == CW'(DEPTH);
  assign top_addr    = entry_q[0];
  assign second_addr = entry_q[1];
  assign depth       = depth_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  // decode {push,pop}; replace on an empty stack behaves as a plain push
  always_comb begin
    op      = stack_op_e'({push, pop});
    do_push = (op == OP_PUSH || (op == OP_REPLACE && empty)) && !full;
    do_pop  = op == OP_POP && !empty;
    do_repl = op == OP_REPLACE && !empty;
    ovf_ev  = op == OP_PUSH && full;
    unf_ev  = op == OP_POP && empty;
    depth_d = do_push ? depth_q + CW'(1) : do_pop ? depth_q - CW'(1) : depth_q;
`ifdef RSTACK_ERR_STICKY_EN
    ovf_d   = ovf_ev | (ovf_q & ~err_clr);
    unf_d   = unf_ev | (unf_q & ~err_clr);
`else
    ovf_d   = ovf_ev;
    unf_d   = unf_ev;
`endif
  end
  // shift network: push moves entries down, pop moves them up and zero-fills the bottom
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [AW-1:0] up, dn;
    if (g == 0) begin : g_top
      assign up = push_addr;
    end else begin : g_mid
      assign up = entry_q[g-1];
    end
    if (g == DEPTH - 1) begin : g_bot
      assign dn = '0;
    end else begin : g_nxt
      assign dn = entry_q[g+1];
    end
    assign entry_d[g] = do_push ? up : do_pop ? dn : (do_repl && g == 0) ? push_addr : entry_q[g];
  end
  // state registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry_q <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
endmodule

// File: tb/tb_microseq_return_stack.sv
// tb_microseq_return_stack: table-driven directed checks of the return stack
module tb_microseq_return_stack;
  typedef struct {
    logic        push, pop;
    logic [31:0] addr, top, sec;
    logic [2:0]  dep;
    logic        emp, ful, ovf, unf;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push = 1'b0, pop = 1'b0;
  logic [31:0] push_addr = '0;
  logic [31:0] top_addr, second_addr;
  logic [2:0]  depth;
  logic        empty, full, overflow, underflow;
`ifdef RSTACK_ERR_STICKY_EN
  logic        err_clr = 1'b0;
`endif
  int checks = 0, errors = 0;
  logic s_ovf = 1'b0, s_unf = 1'b0;
  vec_t tbl[22];
  microseq_return_stack dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .push_addr(push_addr),
`ifdef RSTACK_ERR_STICKY_EN
    .err_clr(err_clr),
`endif
    .top_addr(top_addr), .second_addr(second_addr), .depth(depth),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] t, input logic [31:0] s, input logic [2:0] d,
                       input logic e, input logic f, input logic o, input logic u);
    logic [71:0] act, exp;
    act = {top_addr, second_addr, depth, empty, full, overflow, underflow};
    exp = {t, s, d, e, f, o, u};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got top=%h sec=%h depth=%0d e=%b f=%b ovf=%b unf=%b, want top=%h sec=%h depth=%0d e=%b f=%b ovf=%b unf=%b",
               name, top_addr, second_addr, depth, empty, full, overflow, underflow, t, s, d, e, f, o, u);
    end
  endtask
  task automatic step(input logic pu, input logic po, input logic [31:0] a);
    @(negedge clk);
    push = pu; pop = po; push_addr = a;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{1, 0, 32'h10, 32'h10, 32'h00, 3'd1, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 32'h20, 32'h20, 32'h10, 3'd2, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 32'h30, 32'h30, 32'h20, 3'd3, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 32'h00, 32'h20, 32'h10, 3'd2, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 32'h00, 32'h10, 32'h00, 3'd1, 0, 0, 0, 0};
    tbl[5]  = '{0, 1, 32'h00, 32'h00, 32'h00, 3'd0, 1, 0, 0, 0};
    tbl[6]  = '{0, 1, 32'h00, 32'h00, 32'h00, 3'd0, 1, 0, 0, 1};
    tbl[7]  = '{0, 0, 32'h00, 32'h00, 32'h00, 3'd0, 1, 0, 0, 0};
    tbl[8]  = '{1, 0, 32'h01, 32'h01, 32'h00, 3'd1, 0, 0, 0, 0};
    tbl[9]  = '{1, 0, 32'h02, 32'h02, 32'h01, 3'd2, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 32'h03, 32'h03, 32'h02, 3'd3, 0, 0, 0, 0};
    tbl[11] = '{1, 0, 32'h04, 32'h04, 32'h03, 3'd4, 0, 1, 0, 0};
    tbl[12] = '{1, 0, 32'h05, 32'h04, 32'h03, 3'd4, 0, 1, 1, 0};
    tbl[13] = '{0, 0, 32'h00, 32'h04, 32'h03, 3'd4, 0, 1, 0, 0};
    tbl[14] = '{1, 1, 32'h99, 32'h99, 32'h03, 3'd4, 0, 1, 0, 0};
    tbl[15] = '{0, 1, 32'h00, 32'h03, 32'h02, 3'd3, 0, 0, 0, 0};
    tbl[16] = '{0, 1, 32'h00, 32'h02, 32'h01, 3'd2, 0, 0, 0, 0};
    tbl[17] = '{1, 1, 32'h77, 32'h77, 32'h01, 3'd2, 0, 0, 0, 0};
    tbl[18] = '{0, 1, 32'h00, 32'h01, 32'h00, 3'd1, 0, 0, 0, 0};
    tbl[19] = '{0, 1, 32'h00, 32'h00, 32'h00, 3'd0, 1, 0, 0, 0};
    tbl[20] = '{1, 1, 32'h99, 32'h99, 32'h00, 3'd1, 0, 0, 0, 0};
    tbl[21] = '{0, 1, 32'h00, 32'h00, 32'h00, 3'd0, 1, 0, 0, 0};
    #1;
    check("reset_state", 32'h0, 32'h0, 3'd0, 1, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 22; i++) begin
      step(tbl[i].push, tbl[i].pop, tbl[i].addr);
      s_ovf = tbl[i].ovf | s_ovf;
      s_unf = tbl[i].unf | s_unf;
`ifdef RSTACK_ERR_STICKY_EN
      check($sformatf("vec%0d", i), tbl[i].top, tbl[i].sec, tbl[i].dep, tbl[i].emp, tbl[i].ful, s_ovf, s_unf);
`else
      check($sformatf("vec%0d", i), tbl[i].top, tbl[i].sec, tbl[i].dep, tbl[i].emp, tbl[i].ful, tbl[i].ovf, tbl[i].unf);
`endif
    end
`ifdef RSTACK_ERR_STICKY_EN
    step(0, 0, 32'h0);
    check("sticky_hold", 32'h0, 32'h0, 3'd0, 1, 0, 1, 1);
    @(negedge clk);
    err_clr = 1'b1; pop = 1'b1;
    @(posedge clk);
    #1;
    check("sticky_new_err_wins", 32'h0, 32'h0, 3'd0, 1, 0, 0, 1);
    @(negedge clk);
    pop = 1'b0;
    @(posedge clk);
    #1;
    check("sticky_clear", 32'h0, 32'h0, 3'd0, 1, 0, 0, 0);
    @(negedge clk);
    err_clr = 1'b0;
`endif
    step(1, 0, 32'hA1);
    step(1, 0, 32'hA2);
    step(1, 0, 32'hA3);
    check("pre_async_reset", 32'hA3, 32'hA2, 3'd3, 0, 0, 0, 0);
    @(negedge clk);
    push = 1'b1; push_addr = 32'hA4;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_immediate", 32'h0, 32'h0, 3'd0, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    check("reset_beats_push", 32'h0, 32'h0, 3'd0, 1, 0, 0, 0);
    @(negedge clk);
    push = 1'b0;
    reset = 1'b1;
    step(1, 0, 32'hB1);
    check("post_reset_push", 32'hB1, 32'h0, 3'd1, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
